// File: rtl/pwm_multi_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_multi_channel                                            |
// | Description : Shared-counter multi-channel PWM with prescaler, channel     |
// |               enables and boundary-loaded period/duty shadow registers.    |
// |               Optional per-channel output polarity: PWM_MC_POLARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_multi_channel #(
  parameter  int WIDTH    = 12,
  parameter  int CHANNELS = 4,
  parameter  int PRESC_W  = 8,
  localparam int CH_AW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_reg,
  input  logic [CH_AW-1:0]    wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [1:0]         c_reg_period = 2'd0;
  localparam logic [1:0]         c_reg_duty   = 2'd1;
  localparam logic [1:0]         c_reg_presc  = 2'd2;
  localparam logic [1:0]         c_reg_ctrl   = 2'd3;
  localparam logic [WIDTH-1:0]   c_cnt_one    = WIDTH'(1);
  localparam logic [PRESC_W-1:0] c_psc_one    = PRESC_W'(1);

  logic [WIDTH-1:0]    r_per_p;
  logic [WIDTH-1:0]    r_per_a;
  logic [WIDTH-1:0]    r_cnt;
  logic [PRESC_W-1:0]  r_presc;
  logic [PRESC_W-1:0]  r_psc_cnt;
  logic [CHANNELS-1:0] r_en_mask;
  logic [CHANNELS-1:0] w_pol_mask;
  logic                w_running;
  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic                w_presc_wr;
  logic                w_ctrl_wr;

  assign w_running  = (r_per_a != '0);
  assign w_tick     = w_running && (r_psc_cnt == r_presc);
  // per_a - 1 only matters while running; w_tick already implies that
  assign w_wrap     = w_tick && (r_cnt == (r_per_a - c_cnt_one));
  assign w_load     = !w_running || w_wrap;
  assign w_presc_wr = wr_en && (wr_reg == c_reg_presc);
  assign w_ctrl_wr  = wr_en && (wr_reg == c_reg_ctrl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_p   <= '0;
      r_presc   <= '0;
      r_en_mask <= '0;
    end else begin
      if (wr_en && (wr_reg == c_reg_period)) r_per_p <= wr_data;
      if (w_presc_wr) r_presc <= wr_data[PRESC_W-1:0];
      if (w_ctrl_wr) r_en_mask <= wr_data[CHANNELS-1:0];
    end
  end

`ifdef PWM_MC_POLARITY_EN
  logic [CHANNELS-1:0] r_pol_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pol_mask <= '0;
    end else if (w_ctrl_wr) begin
      r_pol_mask <= wr_data[2*CHANNELS-1:CHANNELS];
    end
  end

  assign w_pol_mask = r_pol_mask;
`else
  assign w_pol_mask = '0;
`endif

  // A prescale write restarts the divider so the new ratio begins cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc_cnt <= '0;
    end else if (!w_running || w_presc_wr || w_tick) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + c_psc_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_per_a     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= w_wrap;
      if (w_load) r_per_a <= r_per_p;
      if (!w_running || w_wrap) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [CH_AW-1:0] c_idx = CH_AW'(gi);

    logic [WIDTH-1:0] r_duty_p;
    logic [WIDTH-1:0] r_duty_a;
    logic             r_pwm;
    logic             w_duty_wr;
    logic             w_raw;

    // Indices with no matching channel never decode, so such writes are dropped
    assign w_duty_wr = wr_en && (wr_reg == c_reg_duty) && (wr_ch == c_idx);
    assign w_raw     = r_en_mask[gi] && w_running && (r_cnt < r_duty_a);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty_p <= '0;
        r_duty_a <= '0;
        r_pwm    <= 1'b0;
      end else begin
        if (w_duty_wr) r_duty_p <= wr_data;
        if (w_load) r_duty_a <= r_duty_p;
        r_pwm <= w_raw ^ w_pol_mask[gi];
      end
    end

    assign pwm_out[gi] = r_pwm;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_multi_channel                                         |
// | Description : Directed self-checking bench for pwm_multi_channel.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_multi_channel;

  localparam int WIDTH    = 12;
  localparam int CHANNELS = 4;
  localparam int PRESC_W  = 8;
  localparam int HIST_N   = 4096;

  localparam logic [1:0] c_reg_period = 2'd0;
  localparam logic [1:0] c_reg_duty   = 2'd1;
  localparam logic [1:0] c_reg_presc  = 2'd2;
  localparam logic [1:0] c_reg_ctrl   = 2'd3;

`ifdef PWM_MC_POLARITY_EN
  localparam int c_pol = 1;
`else
  localparam int c_pol = 0;
`endif

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                wr_en   = 1'b0;
  logic [1:0]          wr_reg  = 2'd0;
  logic [1:0]          wr_ch   = 2'd0;
  logic [WIDTH-1:0]    wr_data = '0;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;

  logic [CHANNELS-1:0] hist_pwm  [0:HIST_N-1];
  logic                hist_tick [0:HIST_N-1];

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .PRESC_W  (PRESC_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  // Log outputs shortly after every rising edge, indexed by edge number
  always @(posedge clk) begin
    #2;
    if (n_edge < HIST_N) begin
      hist_pwm[n_edge]  = pwm_out;
      hist_tick[n_edge] = period_tick;
    end
    n_edge = n_edge + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bit_at(input int idx, input int ch);
    if (idx < 0 || idx >= HIST_N) return -1;
    return int'(hist_pwm[idx][ch]);
  endfunction

  function automatic int hi_cnt(input int ch, input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += bit_at(i, ch);
    return s;
  endfunction

  function automatic int tick_cnt(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < HIST_N) s += int'(hist_tick[i]);
    return s;
  endfunction

  // Called on a falling edge; the write is captured by the next rising edge
  task automatic do_write(input logic [1:0] r, input logic [1:0] ch, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_reg  = r;
    wr_ch   = ch;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the edge index that registered the next period_tick
  task automatic wait_tick(output int wt);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_tick && k < 64);
    check("wait_tick", int'(period_tick), 1);
    wt = n_edge - 1;
  endtask

  initial begin
    int w, e0;

    run(3);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    run(1);

    // Basic period 10, duties 3 / 15 / 0 / 5
    do_write(c_reg_duty, 2'd0, 12'd3);
    do_write(c_reg_duty, 2'd1, 12'd15);
    do_write(c_reg_duty, 2'd2, 12'd0);
    do_write(c_reg_duty, 2'd3, 12'd5);
    do_write(c_reg_presc, 2'd0, 12'd0);
    do_write(c_reg_ctrl, 2'd0, 12'h00F);
    e0 = n_edge;
    do_write(c_reg_period, 2'd0, 12'd10);
    wait_tick(w);
    check("first_tick_edge", w, e0 + 11);
    check("first_clk_low", bit_at(e0 + 1, 0), 0);
    check("first_high", bit_at(e0 + 2, 0), 1);
    run(12);
    check("ch0_high3", hi_cnt(0, w + 1, w + 10), 3);
    check("ch0_cnt2_hi", bit_at(w + 3, 0), 1);
    check("ch0_cnt3_lo", bit_at(w + 4, 0), 0);
    check("ch1_full", hi_cnt(1, w + 1, w + 12), 12);
    check("ch2_zero", hi_cnt(2, w + 1, w + 12), 0);
    check("ch3_high5", hi_cnt(3, w + 1, w + 10), 5);
    check("tick_at_10", int'(hist_tick[w + 10]), 1);
    check("tick_gap", tick_cnt(w + 1, w + 9), 0);

    // Duty 3 -> 6 written at cnt=5
    wait_tick(w);
    run(5);
    do_write(c_reg_duty, 2'd0, 12'd6);
    run(20);
    check("shadow_cur", hi_cnt(0, w + 1, w + 10), 3);
    check("shadow_next", hi_cnt(0, w + 11, w + 20), 6);

    // Period 10 -> 6 written at cnt=5
    wait_tick(w);
    run(5);
    do_write(c_reg_period, 2'd0, 12'd6);
    run(20);
    check("per_old_tick", int'(hist_tick[w + 10]), 1);
    check("per_new_gap", tick_cnt(w + 11, w + 15), 0);
    check("per_new_tick", int'(hist_tick[w + 16]), 1);
    check("per_ch3_5of6", hi_cnt(3, w + 11, w + 16), 5);
    check("per_ch0_full", hi_cnt(0, w + 11, w + 22), 12);

    // Prescaler 1, period 4, duty0 2
    do_write(c_reg_duty, 2'd0, 12'd2);
    do_write(c_reg_period, 2'd0, 12'd4);
    do_write(c_reg_presc, 2'd0, 12'd1);
    wait_tick(w);
    wait_tick(w);
    run(10);
    check("psc_high4", hi_cnt(0, w + 1, w + 8), 4);
    check("psc_hi_edge", bit_at(w + 4, 0), 1);
    check("psc_lo_edge", bit_at(w + 5, 0), 0);
    check("psc_tick8", int'(hist_tick[w + 8]), 1);
    check("psc_gap", tick_cnt(w + 1, w + 7), 0);

    // Enable mask 0xF -> 0xB at cnt=1, then back
    do_write(c_reg_presc, 2'd0, 12'd0);
    do_write(c_reg_period, 2'd0, 12'd10);
    do_write(c_reg_duty, 2'd0, 12'd3);
    do_write(c_reg_duty, 2'd2, 12'd8);
    wait_tick(w);
    wait_tick(w);
    run(1);
    do_write(c_reg_ctrl, 2'd0, 12'h00B);
    run(2);
    do_write(c_reg_ctrl, 2'd0, 12'h00F);
    run(3);
    check("en_ch2_before", bit_at(w + 2, 2), 1);
    check("en_ch2_off", bit_at(w + 3, 2), 0);
    check("en_others", int'(hist_pwm[w + 3] & 4'b1011), 11);
    check("en_ch2_still_off", bit_at(w + 5, 2), 0);
    check("en_ch2_resume", bit_at(w + 6, 2), 1);

    // Asynchronous reset in mid-period
    check("pre_reset_ch1", int'(pwm_out[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_tick", int'(period_tick), 0);
    run(2);
    rst_n = 1'b1;
    run(5);
    check("idle_pwm", int'(pwm_out), 0);
    check("idle_tick", int'(period_tick), 0);

    // Polarity bits (ignored unless the polarity option is built in)
    do_write(c_reg_duty, 2'd0, 12'd3);
    do_write(c_reg_duty, 2'd1, 12'd15);
    do_write(c_reg_ctrl, 2'd0, 12'h01F);
    do_write(c_reg_period, 2'd0, 12'd10);
    wait_tick(w);
    wait_tick(w);
    run(10);
    check("pol_ch0_high", hi_cnt(0, w + 1, w + 10), (c_pol != 0) ? 7 : 3);
    check("pol_ch0_first", bit_at(w + 1, 0), (c_pol != 0) ? 0 : 1);
    check("pol_ch1_full", hi_cnt(1, w + 1, w + 10), 10);
    do_write(c_reg_ctrl, 2'd0, 12'h01E);
    run(2);
    wait_tick(w);
    run(10);
    check("pol_ch0_disabled", hi_cnt(0, w + 1, w + 10), (c_pol != 0) ? 10 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
